// File: rtl/ready_valid_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ready_valid_unpacker_pkg
// Description : Shared helpers for the ready-valid width unpacker.
//               clog2_min1 returns the bit width needed to index `value`
//               items. It never returns less than 1, so a counter sized
//               with it always has at least one bit.
// Revision    : 1.0 - initial release
// ============================================================================
package ready_valid_unpacker_pkg;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ready_valid_unpacker_skid.sv
`default_nettype none
// ============================================================================
// Module      : ready_valid_unpacker_skid
// Description : Two-entry ready-valid skid stage. It fully registers the
//               downstream interface. The upstream ready is registered, so
//               there is no combinational path from i_ready to o_ready.
// Ports       : clk, reset_n    - clock, asynchronous active-low reset
//               i_valid/i_data  - upstream beat
//               o_ready         - stage can take a beat (to upstream)
//               o_valid/o_data  - registered beat (to downstream)
//               i_ready         - downstream accepts the beat
// Revision    : 1.0 - initial release
// ============================================================================
module ready_valid_unpacker_skid #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_push;
    logic             w_pop;

    // The skid entry is only occupied while the output entry is stalled,
    // so a free skid entry guarantees room for one more beat.
    assign o_ready = !r_skid_valid;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign w_push  = i_valid && !r_skid_valid;
    assign w_pop   = r_valid && i_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (r_skid_valid) begin
            // Upstream is blocked; the parked beat moves forward once the
            // output entry drains.
            if (w_pop) begin
                r_data       <= r_skid_data;
                r_skid_valid <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_valid || w_pop) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else begin
                r_skid_data  <= i_data;
                r_skid_valid <= 1'b1;
            end
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ready_valid_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : ready_valid_unpacker
// Description : Ready-valid width converter. It accepts one wide word per
//               handshake, holding up to RATIO beats, and replays it LSB-first
//               as narrow beats. The final beat of each word is tagged with
//               out_last. The next word loads on the same edge that the last
//               beat leaves, so back-to-back words stream without a bubble.
// Ports       : clk, reset_n            - clock, asynchronous active-low reset
//               in_valid/in_data/in_len - wide word; in_len is beats minus 1
//               in_ready                - block can take a word this cycle
//               out_valid/out_data/out_last - narrow beat stream
//               out_ready               - downstream accepts the beat
// Revision    : 1.0 - initial release
// ============================================================================
module ready_valid_unpacker
    import ready_valid_unpacker_pkg::*;
#(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4,
    parameter bit OUT_SKID  = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    input  logic [OUT_WIDTH*RATIO-1:0]       in_data,
    input  logic [clog2_min1(RATIO)-1:0]     in_len,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic                             out_last,
    input  logic                             out_ready
);

    localparam int IN_WIDTH = OUT_WIDTH * RATIO;
    localparam int LEN_W    = clog2_min1(RATIO);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IN_WIDTH-1:0]  r_word;
    logic [LEN_W-1:0]     r_idx;
    logic [LEN_W-1:0]     r_len;

    logic                 w_core_valid;
    logic [OUT_WIDTH-1:0] w_core_data;
    logic                 w_core_last;
    logic                 w_core_ready;
    logic                 w_beat_fire;
    logic                 w_word_fire;
    logic                 w_in_ready;

    assign w_core_valid = (r_state == S_DRAIN);
    assign w_core_data  = r_word[int'(r_idx)*OUT_WIDTH +: OUT_WIDTH];
    assign w_core_last  = w_core_valid && (r_idx == r_len);
    assign w_beat_fire  = w_core_valid && w_core_ready;

    // A new word may enter while the last beat of the current one is being
    // accepted. in_ready depends on out_ready only, never on in_valid.
    assign w_in_ready   = !w_core_valid || (w_beat_fire && w_core_last);
    assign w_word_fire  = in_valid && w_in_ready;
    assign in_ready     = w_in_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_word_fire) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_beat_fire && w_core_last && !w_word_fire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register and beat counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word <= '0;
            r_len  <= '0;
            r_idx  <= '0;
        end else if (w_word_fire) begin
            r_word <= in_data;
            r_len  <= in_len;
            r_idx  <= '0;
        end else if (w_beat_fire && !w_core_last) begin
            r_idx  <= r_idx + LEN_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    generate
        if (OUT_SKID) begin : g_skid
            logic [OUT_WIDTH:0] w_skid_data;

            ready_valid_unpacker_skid #(
                .WIDTH (OUT_WIDTH + 1)
            ) u_skid (
                .clk     (clk),
                .reset_n (reset_n),
                .i_valid (w_core_valid),
                .i_data  ({w_core_last, w_core_data}),
                .o_ready (w_core_ready),
                .o_valid (out_valid),
                .o_data  (w_skid_data),
                .i_ready (out_ready)
            );

            assign out_last = w_skid_data[OUT_WIDTH];
            assign out_data = w_skid_data[OUT_WIDTH-1:0];
        end else begin : g_bypass
            assign w_core_ready = out_ready;
            assign out_valid    = w_core_valid;
            assign out_data     = w_core_data;
            assign out_last     = w_core_last;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ready_valid_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ready_valid_unpacker
// Description : Directed and soak checks for ready_valid_unpacker, with one
//               instance without the output skid stage and one with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ready_valid_unpacker;

    localparam int NW   = 4096;
    localparam int SOAK = 10000;

    logic        clk;
    logic        reset_n;

    logic        in_valid, in_ready, out_valid, out_last, out_ready;
    logic [31:0] in_data;
    logic [1:0]  in_len;
    logic [7:0]  out_data;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_last, s_out_ready;
    logic [31:0] s_in_data;
    logic [1:0]  s_in_len;
    logic [7:0]  s_out_data;

    int n_cmp;
    int n_fail;

    logic [31:0] sk_words [NW];
    logic [1:0]  sk_lens  [NW];
    logic [8:0]  q0 [$];
    logic [8:0]  q1 [$];

    ready_valid_unpacker #(.OUT_WIDTH(8), .RATIO(4), .OUT_SKID(1'b0)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_len(in_len), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
    );

    ready_valid_unpacker #(.OUT_WIDTH(8), .RATIO(4), .OUT_SKID(1'b1)) u_dut_skid (
        .clk(clk), .reset_n(reset_n),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_len(s_in_len), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last), .out_ready(s_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_init: got valid=%b last=%b ready=%b data=%h expected 0 0 1 00", out_valid, out_last, in_ready, out_data);
        end
        step(); step();
        reset_n = 1'b1;
        step();
        in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_len = 2'd3;
        s_in_valid = 1'b1; s_in_data = 32'hDDCCBBAA; s_in_len = 2'd3;
        step();
        in_valid = 1'b0; s_in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hAA) begin
            n_fail++; $display("FAIL reset_beat0: got valid=%b data=%h expected 1 aa", out_valid, out_data);
        end
        step();
        step();
        // Assert reset mid-drain, between clock edges.
        reset_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_async: got valid=%b last=%b ready=%b data=%h expected 0 0 1 00", out_valid, out_last, in_ready, out_data);
        end
        n_cmp++; if (s_out_valid !== 1'b0 || s_out_last !== 1'b0 || s_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_async_skid: got valid=%b last=%b ready=%b expected 0 0 1", s_out_valid, s_out_last, s_in_ready);
        end
        step();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_held: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0 || s_out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL reset_residual k=%0d: got valid=%b skid_valid=%b ready=%b expected 0 0 1", k, out_valid, s_out_valid, in_ready);
            end
        end
    endtask

    task automatic test_single_word();
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h44332211; in_len = 2'd3;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_in_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0; in_data = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_b[k] || out_last !== (k == 3)) begin
                n_fail++; $display("FAIL single_beat k=%0d: got valid=%b data=%h last=%b expected 1 %h %b", k, out_valid, out_data, out_last, exp_b[k], (k == 3));
            end
            step();
        end
        n_cmp++; if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_done: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_short_word();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h000000AB; in_len = 2'd0;
        step();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hAB || out_last !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL short_beat: got valid=%b data=%h last=%b ready=%b expected 1 ab 1 1", out_valid, out_data, out_last, in_ready);
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL short_done: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [8];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h44332211; in_len = 2'd3;
        step();
        in_data = 32'h88776655;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_b[k] || out_last !== (k == 3 || k == 7)) begin
                n_fail++; $display("FAIL b2b_beat k=%0d: got valid=%b data=%h last=%b expected 1 %h %b", k, out_valid, out_data, out_last, exp_b[k], (k == 3 || k == 7));
            end
            n_cmp++; if (in_ready !== (k == 3 || k == 7)) begin
                n_fail++; $display("FAIL b2b_in_ready k=%0d: got %b expected %b", k, in_ready, (k == 3 || k == 7));
            end
            step();
            if (k == 3) begin
                in_valid = 1'b0;
            end
        end
        n_cmp++; if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_done: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_output_stall();
        logic [7:0] exp_b [3];
        exp_b = '{8'h22, 8'h33, 8'h44};
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h44332211; in_len = 2'd3;
        step();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_data !== 8'h11) begin
            n_fail++; $display("FAIL stall_beat0: got %h expected 11", out_data);
        end
        step();
        out_ready = 1'b0;
        // A competing word is offered during the stall and must not be taken.
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_len = 2'd3;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_last !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold k=%0d: got valid=%b data=%h last=%b ready=%b expected 1 22 0 0", k, out_valid, out_data, out_last, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_b[k] || out_last !== (k == 2)) begin
                n_fail++; $display("FAIL stall_resume k=%0d: got valid=%b data=%h last=%b expected 1 %h %b", k, out_valid, out_data, out_last, exp_b[k], (k == 2));
            end
            step();
        end
        n_cmp++; if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_done: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_skid_latency();
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        s_out_ready = 1'b1;
        s_in_valid = 1'b1; s_in_data = 32'h44332211; s_in_len = 2'd3;
        #1;
        n_cmp++; if (s_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL skid_in_ready: got %b expected 1", s_in_ready);
        end
        step();
        s_in_valid = 1'b0;
        #1;
        n_cmp++; if (s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL skid_n1: got valid=%b expected 0", s_out_valid);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== exp_b[k] || s_out_last !== (k == 3)) begin
                n_fail++; $display("FAIL skid_beat k=%0d: got valid=%b data=%h last=%b expected 1 %h %b", k, s_out_valid, s_out_data, s_out_last, exp_b[k], (k == 3));
            end
            step();
        end
        n_cmp++; if (s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL skid_done: got valid=%b expected 0", s_out_valid);
        end
    endtask

    task automatic test_random_soak();
        int wi0, wi1, wl0, wl1;
        logic [8:0] exp;
        wi0 = 0; wi1 = 0; wl0 = 0; wl1 = 0;
        q0.delete(); q1.delete();
        for (int i = 0; i < NW; i++) begin
            sk_words[i] = $urandom;
            sk_lens[i]  = 2'($urandom_range(0, 3));
        end
        for (int cyc = 0; cyc < SOAK + 40; cyc++) begin
            if (cyc < SOAK) begin
                out_ready   = ($urandom_range(0, 3) != 0);
                in_valid    = ($urandom_range(0, 1) == 1) && (wi0 < NW);
                s_out_ready = ($urandom_range(0, 3) != 0);
                s_in_valid  = ($urandom_range(0, 1) == 1) && (wi1 < NW);
            end else begin
                out_ready = 1'b1; in_valid = 1'b0;
                s_out_ready = 1'b1; s_in_valid = 1'b0;
            end
            in_data    = in_valid   ? sk_words[wi0] : $urandom;
            in_len     = in_valid   ? sk_lens[wi0]  : 2'($urandom);
            s_in_data  = s_in_valid ? sk_words[wi1] : $urandom;
            s_in_len   = s_in_valid ? sk_lens[wi1]  : 2'($urandom);
            #1;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q0.size() == 0) begin
                    n_fail++; $display("FAIL soak_unexpected cyc=%0d: got beat %h with no beat expected", cyc, out_data);
                end else begin
                    exp = q0.pop_front();
                    if ({out_last, out_data} !== exp) begin
                        n_fail++; $display("FAIL soak_beat cyc=%0d: got last=%b data=%h expected last=%b data=%h", cyc, out_last, out_data, exp[8], exp[7:0]);
                    end
                    if (out_last) wl0++;
                end
            end
            if (s_out_valid && s_out_ready) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_fail++; $display("FAIL soak_skid_unexpected cyc=%0d: got beat %h with no beat expected", cyc, s_out_data);
                end else begin
                    exp = q1.pop_front();
                    if ({s_out_last, s_out_data} !== exp) begin
                        n_fail++; $display("FAIL soak_skid_beat cyc=%0d: got last=%b data=%h expected last=%b data=%h", cyc, s_out_last, s_out_data, exp[8], exp[7:0]);
                    end
                    if (s_out_last) wl1++;
                end
            end
            if (in_valid && in_ready) begin
                for (int b = 0; b <= int'(sk_lens[wi0]); b++) begin
                    q0.push_back({(b == int'(sk_lens[wi0])), sk_words[wi0][b*8 +: 8]});
                end
                wi0++;
            end
            if (s_in_valid && s_in_ready) begin
                for (int b = 0; b <= int'(sk_lens[wi1]); b++) begin
                    q1.push_back({(b == int'(sk_lens[wi1])), sk_words[wi1][b*8 +: 8]});
                end
                wi1++;
            end
            step();
        end
        n_cmp++; if (q0.size() != 0 || wl0 != wi0 || wi0 < 100) begin
            n_fail++; $display("FAIL soak_words: got %0d words out, %0d beats left expected %0d words out, 0 left", wl0, q0.size(), wi0);
        end
        n_cmp++; if (q1.size() != 0 || wl1 != wi1 || wi1 < 100) begin
            n_fail++; $display("FAIL soak_skid_words: got %0d words out, %0d beats left expected %0d words out, 0 left", wl1, q1.size(), wi1);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_len = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = '0; s_in_len = '0; s_out_ready = 1'b1;
        test_reset();
        test_single_word();
        test_short_word();
        test_back_to_back();
        test_output_stall();
        test_skid_latency();
        test_random_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
